camera_handoff_ctrl: RTL and testbench
======================================

# camera_handoff_ctrl

Sequences the two camera buffers of the space-station dual-camera system. The block watches both buffer fill levels, in tenths of full. It raises standby and film requests so that filming passes from one camera to the other. It decides whether each retired buffer is downloaded or flushed, and it grants the single microcontroller download port to one buffer at a time. It sits between the two Percents/Buffer datapaths and the microcontroller PIO, and replaces the ad-hoc cross-wiring of camera out-signals.

## Interface
- `STANDBY_PCT`, default 8: active-buffer level at which the idle camera is put on standby.
- `HANDOFF_PCT`, default 9: active-buffer level at which the idle camera starts filming.
- `FLUSH_PCT`, default 5: new-buffer level at which an unrequested retired buffer is flushed.
- `FULL_PCT`, default 10: full level; the active buffer is paused here.
- `clock` in, 1 bit: system clock (divided clock).
- `reset` in, 1 bit: asynchronous, active-high.
- `start` in, 1 bit: level; begins filming from IDLE.
- `first_cam` in, 1 bit: camera (0/1) that films first after start.
- `pct0`, `pct1` in, 4 bits each: buffer fill levels 0..10. Values above 10 are treated as 10.
- `dl_req` in, 1 bit: single-cycle pulse; download request for the retired buffer.
- `standby` out, 2 bits: per-camera standby request.
- `film` out, 2 bits: per-camera film request; buffer fills.
- `empty_buf` out, 2 bits: per-camera buffer drains.
- `pause_buf` out, 2 bits: per-camera buffer holds its level.
- `dl_active` out, 1 bit: a download is in progress.
- `dl_sel` out, 1 bit: camera granted to the download port.
- `ready_to_download` out, 1 bit: a retired buffer is held and awaiting `dl_req`.
- `active_cam` out, 1 bit: camera currently filming.

## Operation
- Main FSM: IDLE, FILM, STANDBY, HANDOFF, STALL. A = `active_cam`, B = the other camera.
- IDLE: all requests are low and both buffers are paused. When `start` is high, go to FILM with A = `first_cam`.
- FILM: `film[A]`=1. When pct[A] >= STANDBY_PCT, go to STANDBY.
- STANDBY: `film[A]`=1 and `standby[B]`=1. When pct[A] >= HANDOFF_PCT:
  - if B's drain FSM is D_IDLE and pct[B]==0, go to HANDOFF;
  - otherwise go to STALL.
- STALL: `standby[B]`=1. A keeps filming until pct[A] == FULL_PCT, then `pause_buf[A]`=1. Go to HANDOFF as soon as B is empty and idle.
- HANDOFF, one cycle: `film[B]`=1, A's drain FSM goes to D_HOLD, and A and B swap. Next state is FILM.
- Drain FSM, one per camera: D_IDLE, D_HOLD, D_DOWNLOAD, D_FLUSH.
  - D_HOLD: `pause_buf`=1 and `ready_to_download`=1.
  - `dl_req` in D_HOLD goes to D_DOWNLOAD, with `empty_buf`=1, `dl_active`=1, and `dl_sel` set to this camera.
  - When the new active buffer reaches FLUSH_PCT in D_HOLD, go to D_FLUSH with `empty_buf`=1 (see Configuration).
  - D_DOWNLOAD and D_FLUSH return to D_IDLE when the buffer's pct is 0.
- Only one buffer can be retired at a time, because of the STALL gating. `dl_req` when no buffer is in D_HOLD is ignored.
- `dl_req` and the flush threshold in the same cycle: the download wins.
- `empty_buf` and `pause_buf` are never both high for the same camera. Camera signals that are neither filling nor draining default to pause.
- `reset` at any point: all FSMs return to IDLE/D_IDLE immediately. Buffer contents are abandoned; the datapath clears itself on the same reset.

## Timing
- All outputs are registered.
- Reset values: `standby`=0, `film`=0, `empty_buf`=0, `pause_buf`=2'b11, `dl_active`=0, `dl_sel`=0, `ready_to_download`=0, `active_cam`=0.
- A pct threshold crossing is reflected on the outputs on the next `clock` edge (1-cycle latency).
- `start` to `film[first_cam]`: 1 cycle.
- `dl_req` to `dl_active`: 1 cycle. `dl_active` falls 1 cycle after the granted pct reads 0.
- HANDOFF lasts exactly one cycle. `film[A]` falls on the same edge that `film[B]` rises, so there is no gap and no overlap.

## Configuration
- `CAM_AUTO_FLUSH_EN` defined: D_HOLD flushes automatically at FLUSH_PCT, as described above.
- Not defined: D_HOLD persists until `dl_req`. The following handoff then stays in STALL with the active buffer paused at full until the download completes, and no data is ever discarded.

## Structure
- Shared package `camera_pkg`:
  - main-state and drain-state enums;
  - `PCT_W`=4 and the default threshold constants.
- Sub-module `cam_drain_fsm`, instantiated twice, one per camera. The download grant comes from the main block, which guarantees at most one requester.

## Test plan
- **Start from IDLE.** Reset, then `first_cam`=0 and `start`=1 → `film`=2'b01 after 1 cycle. Ramp pct0 to 8 → `standby[1]`=1. At pct0=9 (pct1=0) → one HANDOFF cycle, then `film`=2'b10 and `ready_to_download`=1.
- **Download.** After handoff, pulse `dl_req` with pct0=9 → `dl_active`=1, `dl_sel`=0, `empty_buf[0]`=1. Ramp pct0 down to 0 → `dl_active`=0 one cycle later.
- **Auto flush.** With `CAM_AUTO_FLUSH_EN` defined and no `dl_req`, pct1 reaches 5 → `empty_buf[0]`=1 and `ready_to_download`=0. Without the macro → pct0 stays paused.
- **Stall.** Camera 1 is active and camera 0 is still downloading at pct0=3 when pct1 hits 9 → STALL. At pct1=10 → `pause_buf[1]`=1. When pct0=0 → handoff to camera 0.
- **Simultaneous events.** `dl_req` arrives on the same cycle pct1 reaches 5 → download is granted and there is no flush.
- **Reset mid-operation.** Assert `reset` during D_DOWNLOAD → all outputs return to their reset values asynchronously, with no clock edge needed.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared state enums, fill-level width and default thresholds for the
// dual-camera handoff controller and its per-camera drain sequencers.
package camera_pkg;

    localparam int PCT_W = 4;

    localparam logic [PCT_W-1:0] DEF_STANDBY_PCT = 4'd8;
    localparam logic [PCT_W-1:0] DEF_HANDOFF_PCT = 4'd9;
    localparam logic [PCT_W-1:0] DEF_FLUSH_PCT   = 4'd5;
    localparam logic [PCT_W-1:0] DEF_FULL_PCT    = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILM,
        ST_STANDBY,
        ST_HANDOFF,
        ST_STALL
    } main_state_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_HOLD,
        D_DOWNLOAD,
        D_FLUSH
    } drain_state_e;

    // Buffer levels above full are reported by the datapath as overflow noise.
    function automatic logic [PCT_W-1:0] sat_pct(input logic [PCT_W-1:0] pct,
                                                input logic [PCT_W-1:0] full);
        return (pct > full) ? full : pct;
    endfunction

endpackage

// File: rtl/cam_drain_fsm.sv
// Per-camera retirement sequencer: holds a retired buffer, then drains it by
// download (when granted) or by flush, returning to idle once it reads empty.
module cam_drain_fsm
    import camera_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         hold_cmd,
    input  logic         dl_grant,
    input  logic         flush_hit,
    input  logic         pct_zero,
    output drain_state_e state_q,
    output drain_state_e state_d
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= D_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A grant in the same cycle as the flush threshold takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            D_IDLE: begin
                if (hold_cmd) state_d = D_HOLD;
            end
            D_HOLD: begin
                if (dl_grant)       state_d = D_DOWNLOAD;
                else if (flush_hit) state_d = D_FLUSH;
            end
            D_DOWNLOAD, D_FLUSH: begin
                if (pct_zero) state_d = D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase
    end

endmodule

// File: rtl/camera_handoff_ctrl.sv
// Dual-camera filming handoff, retirement and download-port arbitration.
// Build option: CAM_AUTO_FLUSH_EN makes held buffers flush at FLUSH_PCT.
module camera_handoff_ctrl
    import camera_pkg::*;
#(
    parameter logic [PCT_W-1:0] STANDBY_PCT = DEF_STANDBY_PCT,
    parameter logic [PCT_W-1:0] HANDOFF_PCT = DEF_HANDOFF_PCT,
    parameter logic [PCT_W-1:0] FLUSH_PCT   = DEF_FLUSH_PCT,
    parameter logic [PCT_W-1:0] FULL_PCT    = DEF_FULL_PCT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             first_cam,
    input  logic [PCT_W-1:0] pct0,
    input  logic [PCT_W-1:0] pct1,
    input  logic             dl_req,
    output logic [1:0]       standby,
    output logic [1:0]       film,
    output logic [1:0]       empty_buf,
    output logic [1:0]       pause_buf,
    output logic             dl_active,
    output logic             dl_sel,
    output logic             ready_to_download,
    output logic             active_cam
);

    main_state_e state_q, state_d;
    logic        active_q, active_d;

    drain_state_e drain_q [2];
    drain_state_e drain_d [2];

    logic [1:0][PCT_W-1:0] pct_s;
    logic [1:0] hold_cmd, dl_grant, flush_hit, pct_zero;
    logic       cam_a, cam_b, b_free;

    logic [1:0] standby_q, standby_d, film_q, film_d;
    logic [1:0] empty_q, empty_d, pause_q, pause_d;
    logic       dl_active_q, dl_active_d, dl_sel_q, dl_sel_d, ready_q, ready_d;

    always_comb begin
        pct_s[0] = sat_pct(pct0, FULL_PCT);
        pct_s[1] = sat_pct(pct1, FULL_PCT);
        pct_zero[0] = (pct_s[0] == '0);
        pct_zero[1] = (pct_s[1] == '0);
    end

    // Only one buffer can be held at a time; camera 0 wins any theoretical tie.
    always_comb begin
        dl_grant[0] = dl_req && (drain_q[0] == D_HOLD);
        dl_grant[1] = dl_req && (drain_q[1] == D_HOLD) && (drain_q[0] != D_HOLD);
`ifdef CAM_AUTO_FLUSH_EN
        flush_hit[0] = (pct_s[1] >= FLUSH_PCT);
        flush_hit[1] = (pct_s[0] >= FLUSH_PCT);
`else
        flush_hit = 2'b00;
`endif
    end

    cam_drain_fsm u_drain0 (
        .clock     (clock),
        .reset     (reset),
        .hold_cmd  (hold_cmd[0]),
        .dl_grant  (dl_grant[0]),
        .flush_hit (flush_hit[0]),
        .pct_zero  (pct_zero[0]),
        .state_q   (drain_q[0]),
        .state_d   (drain_d[0])
    );

    cam_drain_fsm u_drain1 (
        .clock     (clock),
        .reset     (reset),
        .hold_cmd  (hold_cmd[1]),
        .dl_grant  (dl_grant[1]),
        .flush_hit (flush_hit[1]),
        .pct_zero  (pct_zero[1]),
        .state_q   (drain_q[1]),
        .state_d   (drain_d[1])
    );

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        hold_cmd = 2'b00;
        cam_a    = active_q;
        cam_b    = ~active_q;
        b_free   = (drain_q[cam_b] == D_IDLE) && pct_zero[cam_b];
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FILM;
                    active_d = first_cam;
                end
            end
            ST_FILM: begin
                if (pct_s[cam_a] >= STANDBY_PCT) state_d = ST_STANDBY;
            end
            ST_STANDBY: begin
                if (pct_s[cam_a] >= HANDOFF_PCT) state_d = b_free ? ST_HANDOFF : ST_STALL;
            end
            ST_STALL: begin
                if (b_free) state_d = ST_HANDOFF;
            end
            ST_HANDOFF: begin
                state_d         = ST_FILM;
                active_d        = cam_b;
                hold_cmd[cam_a] = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the next state so every request lands on the same edge
    // as the transition that causes it.
    always_comb begin
        film_d    = 2'b00;
        standby_d = 2'b00;
        empty_d   = 2'b00;
        pause_d   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            case (state_d)
                ST_FILM, ST_STANDBY: film_d[i] = (active_d == 1'(i));
                ST_STALL:   film_d[i] = (active_d == 1'(i)) && (pct_s[i] < FULL_PCT);
                ST_HANDOFF: film_d[i] = (active_d != 1'(i));
                default:    film_d[i] = 1'b0;
            endcase
            standby_d[i] = ((state_d == ST_STANDBY) || (state_d == ST_STALL))
                           && (active_d != 1'(i));
            empty_d[i]   = (drain_d[i] == D_DOWNLOAD) || (drain_d[i] == D_FLUSH);
            pause_d[i]   = !film_d[i] && !empty_d[i];
        end
        dl_active_d = (drain_d[0] == D_DOWNLOAD) || (drain_d[1] == D_DOWNLOAD);
        if (drain_d[1] == D_DOWNLOAD)      dl_sel_d = 1'b1;
        else if (drain_d[0] == D_DOWNLOAD) dl_sel_d = 1'b0;
        else                               dl_sel_d = dl_sel_q;
        ready_d = (drain_d[0] == D_HOLD) || (drain_d[1] == D_HOLD);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            active_q    <= 1'b0;
            standby_q   <= 2'b00;
            film_q      <= 2'b00;
            empty_q     <= 2'b00;
            pause_q     <= 2'b11;
            dl_active_q <= 1'b0;
            dl_sel_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            standby_q   <= standby_d;
            film_q      <= film_d;
            empty_q     <= empty_d;
            pause_q     <= pause_d;
            dl_active_q <= dl_active_d;
            dl_sel_q    <= dl_sel_d;
            ready_q     <= ready_d;
        end
    end

    assign standby           = standby_q;
    assign film              = film_q;
    assign empty_buf         = empty_q;
    assign pause_buf         = pause_q;
    assign dl_active         = dl_active_q;
    assign dl_sel            = dl_sel_q;
    assign ready_to_download = ready_q;
    assign active_cam        = active_q;

endmodule

// File: tb/tb_camera_handoff_ctrl.sv
// Self-checking bench for camera_handoff_ctrl: directed scenarios plus a
// closed-loop random run against a flag-based model (follows CAM_AUTO_FLUSH_EN).
module tb_camera_handoff_ctrl;

    logic       clock = 1'b0;
    logic       reset, start, first_cam, dl_req;
    logic [3:0] pct0, pct1;
    logic [1:0] standby, film, empty_buf, pause_buf;
    logic       dl_active, dl_sel, ready_to_download, active_cam;
    logic [11:0] dut_vec;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [11:0] RESET_VEC = 12'b00_00_00_11_0_0_0_0;

    camera_handoff_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .first_cam         (first_cam),
        .pct0              (pct0),
        .pct1              (pct1),
        .dl_req            (dl_req),
        .standby           (standby),
        .film              (film),
        .empty_buf         (empty_buf),
        .pause_buf         (pause_buf),
        .dl_active         (dl_active),
        .dl_sel            (dl_sel),
        .ready_to_download (ready_to_download),
        .active_cam        (active_cam)
    );

    always #5 clock = ~clock;

    assign dut_vec = {standby, film, empty_buf, pause_buf, dl_active, dl_sel,
                      ready_to_download, active_cam};

    // Reference model: camera roles and per-camera retirement flags.
    logic        m_started, m_act, m_warn, m_stall, m_swap, m_full, m_sel;
    logic [1:0]  m_held, m_dl, m_fl;
    logic [11:0] exp_vec;
    logic [11:0] exp_q[$];

    function automatic int sat(input logic [3:0] p);
        return (p > 4'd10) ? 10 : int'(p);
    endfunction

    function automatic logic [11:0] model_outputs();
        logic [1:0] sb, fm, em, pa;
        sb = 2'b00;
        fm = 2'b00;
        if (m_started) begin
            if (m_swap) begin
                fm[!m_act] = 1'b1;
            end else begin
                if (!m_full) fm[m_act] = 1'b1;
                if (m_warn)  sb[!m_act] = 1'b1;
            end
        end
        em = m_dl | m_fl;
        pa = ~(fm | em);
        return {sb, fm, em, pa, |m_dl, m_sel, |m_held, m_act};
    endfunction

    task automatic model_reset();
        m_started = 1'b0; m_act = 1'b0; m_warn = 1'b0; m_stall = 1'b0;
        m_swap = 1'b0; m_full = 1'b0; m_sel = 1'b0;
        m_held = 2'b00; m_dl = 2'b00; m_fl = 2'b00;
        exp_vec = model_outputs();
    endtask

    task automatic model_edge();
        int p[2];
        logic [1:0] h, d, f;
        logic a, bfree;
        p[0] = sat(pct0);
        p[1] = sat(pct1);
        h = m_held; d = m_dl; f = m_fl;
        a = m_act;
        bfree = !h[!a] && !d[!a] && !f[!a] && (p[!a] == 0);
        for (int i = 0; i < 2; i++) begin
            if (h[i]) begin
                if (dl_req) begin
                    m_held[i] = 1'b0; m_dl[i] = 1'b1;
                end
`ifdef CAM_AUTO_FLUSH_EN
                else if (p[1-i] >= 5) begin
                    m_held[i] = 1'b0; m_fl[i] = 1'b1;
                end
`endif
            end else if ((d[i] || f[i]) && p[i] == 0) begin
                m_dl[i] = 1'b0; m_fl[i] = 1'b0;
            end
        end
        if (!m_started) begin
            if (start) begin
                m_started = 1'b1; m_act = first_cam;
            end
        end else if (m_swap) begin
            m_swap = 1'b0; m_warn = 1'b0; m_stall = 1'b0;
            m_held[a] = 1'b1; m_act = !a;
        end else if (!m_warn) begin
            if (p[a] >= 8) m_warn = 1'b1;
        end else if (m_stall || p[a] >= 9) begin
            if (bfree) m_swap = 1'b1;
            else       m_stall = 1'b1;
        end
        m_full = m_stall && !m_swap && (p[m_act] >= 10);
        if (m_dl[1])      m_sel = 1'b1;
        else if (m_dl[0]) m_sel = 1'b0;
        exp_vec = model_outputs();
        exp_q.push_back(exp_vec);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; first_cam = 1'b0; dl_req = 1'b0;
        pct0 = 4'd0; pct1 = 4'd0;
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic set_pct(input logic cam, input int v);
        if (cam) pct1 = 4'(v);
        else     pct0 = 4'(v);
    endtask

    // Films cam up to the handoff level and lets the handoff complete.
    task automatic go_handoff(input logic cam);
        do_reset();
        first_cam = cam; start = 1'b1;
        tick();
        start = 1'b0;
        for (int v = 1; v <= 9; v++) begin
            set_pct(cam, v);
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; first_cam = 1'b0; dl_req = 1'b0;
        pct0 = 4'd0; pct1 = 4'd0;
        #3;
        n_tests++; if (dut_vec !== RESET_VEC) begin n_fail++; $display("FAIL reset_values: got %b expected %b", dut_vec, RESET_VEC); end
        @(posedge clock); #2;
        reset = 1'b0;
        model_reset();
        pct0 = 4'd9;
        tick();
        n_tests++; if (dut_vec !== RESET_VEC) begin n_fail++; $display("FAIL idle_ignores_pct: got %b expected %b", dut_vec, RESET_VEC); end
    endtask

    task automatic test_start_handoff();
        do_reset();
        first_cam = 1'b0; start = 1'b1;
        tick();
        n_tests++; if ({film, active_cam} !== 3'b01_0) begin n_fail++; $display("FAIL start_film: got %b expected %b", {film, active_cam}, 3'b01_0); end
        start = 1'b0;
        for (int v = 1; v <= 7; v++) begin
            pct0 = 4'(v);
            tick();
        end
        n_tests++; if (standby !== 2'b00) begin n_fail++; $display("FAIL no_standby_at_7: got %b expected %b", standby, 2'b00); end
        pct0 = 4'd8;
        tick();
        n_tests++; if ({standby, film} !== 4'b10_01) begin n_fail++; $display("FAIL standby_at_8: got %b expected %b", {standby, film}, 4'b10_01); end
        pct0 = 4'd9;
        tick();
        n_tests++; if ({film, standby, ready_to_download, active_cam} !== 6'b10_00_0_0) begin n_fail++; $display("FAIL handoff_cycle: got %b expected %b", {film, standby, ready_to_download, active_cam}, 6'b10_00_0_0); end
        tick();
        n_tests++; if ({film, pause_buf, ready_to_download, active_cam} !== 6'b10_01_1_1) begin n_fail++; $display("FAIL after_handoff: got %b expected %b", {film, pause_buf, ready_to_download, active_cam}, 6'b10_01_1_1); end
    endtask

    task automatic test_download();
        dl_req = 1'b1;
        tick();
        dl_req = 1'b0;
        n_tests++; if ({dl_active, dl_sel, empty_buf, ready_to_download} !== 5'b1_0_01_0) begin n_fail++; $display("FAIL dl_grant: got %b expected %b", {dl_active, dl_sel, empty_buf, ready_to_download}, 5'b1_0_01_0); end
        for (int v = 8; v >= 1; v--) begin
            pct0 = 4'(v);
            tick();
        end
        n_tests++; if (dl_active !== 1'b1) begin n_fail++; $display("FAIL dl_still_active: got %b expected %b", dl_active, 1'b1); end
        pct0 = 4'd0;
        tick();
        n_tests++; if ({dl_active, empty_buf, pause_buf} !== 5'b0_00_01) begin n_fail++; $display("FAIL dl_done: got %b expected %b", {dl_active, empty_buf, pause_buf}, 5'b0_00_01); end
        dl_req = 1'b1;
        tick();
        dl_req = 1'b0;
        n_tests++; if ({dl_active, empty_buf} !== 3'b0_00) begin n_fail++; $display("FAIL dl_req_ignored: got %b expected %b", {dl_active, empty_buf}, 3'b0_00); end
    endtask

    task automatic test_hold_flush();
        go_handoff(1'b0);
        for (int v = 1; v <= 4; v++) begin
            pct1 = 4'(v);
            tick();
        end
        n_tests++; if (ready_to_download !== 1'b1) begin n_fail++; $display("FAIL hold_before_flush: got %b expected %b", ready_to_download, 1'b1); end
        pct1 = 4'd5;
        tick();
`ifdef CAM_AUTO_FLUSH_EN
        n_tests++; if ({empty_buf, ready_to_download, dl_active} !== 4'b01_0_0) begin n_fail++; $display("FAIL auto_flush: got %b expected %b", {empty_buf, ready_to_download, dl_active}, 4'b01_0_0); end
        for (int v = 8; v >= 0; v--) begin
            pct0 = 4'(v);
            tick();
        end
        n_tests++; if (empty_buf !== 2'b00) begin n_fail++; $display("FAIL flush_done: got %b expected %b", empty_buf, 2'b00); end
`else
        n_tests++; if ({ready_to_download, empty_buf, pause_buf[0]} !== 4'b1_00_1) begin n_fail++; $display("FAIL no_flush: got %b expected %b", {ready_to_download, empty_buf, pause_buf[0]}, 4'b1_00_1); end
        for (int v = 6; v <= 10; v++) begin
            pct1 = 4'(v);
            tick();
        end
        n_tests++; if ({film, pause_buf, ready_to_download} !== 5'b00_11_1) begin n_fail++; $display("FAIL stall_full_hold: got %b expected %b", {film, pause_buf, ready_to_download}, 5'b00_11_1); end
`endif
    endtask

    task automatic test_stall();
        go_handoff(1'b0);
        dl_req = 1'b1;
        tick();
        dl_req = 1'b0;
        for (int v = 8; v >= 3; v--) begin
            pct0 = 4'(v);
            tick();
        end
        for (int v = 1; v <= 9; v++) begin
            pct1 = 4'(v);
            tick();
        end
        n_tests++; if ({film, standby} !== 4'b10_01) begin n_fail++; $display("FAIL stall_entry: got %b expected %b", {film, standby}, 4'b10_01); end
        pct1 = 4'd10;
        tick();
        n_tests++; if ({film, pause_buf, empty_buf} !== 6'b00_10_01) begin n_fail++; $display("FAIL stall_pause_full: got %b expected %b", {film, pause_buf, empty_buf}, 6'b00_10_01); end
        for (int v = 2; v >= 0; v--) begin
            pct0 = 4'(v);
            tick();
        end
        n_tests++; if ({dl_active, film} !== 3'b0_00) begin n_fail++; $display("FAIL stall_drained: got %b expected %b", {dl_active, film}, 3'b0_00); end
        tick();
        n_tests++; if ({film, active_cam} !== 3'b01_1) begin n_fail++; $display("FAIL stall_handoff: got %b expected %b", {film, active_cam}, 3'b01_1); end
        tick();
        n_tests++; if ({film, active_cam, ready_to_download} !== 4'b01_0_1) begin n_fail++; $display("FAIL stall_resume: got %b expected %b", {film, active_cam, ready_to_download}, 4'b01_0_1); end
    endtask

    task automatic test_simultaneous();
        go_handoff(1'b0);
        for (int v = 1; v <= 4; v++) begin
            pct1 = 4'(v);
            tick();
        end
        pct1 = 4'd5; dl_req = 1'b1;
        tick();
        dl_req = 1'b0;
        n_tests++; if ({dl_active, dl_sel, empty_buf, ready_to_download} !== 5'b1_0_01_0) begin n_fail++; $display("FAIL dl_beats_flush: got %b expected %b", {dl_active, dl_sel, empty_buf, ready_to_download}, 5'b1_0_01_0); end
    endtask

    task automatic test_reset_mid();
        pct0 = 4'd7;
        tick();
        n_tests++; if (dl_active !== 1'b1) begin n_fail++; $display("FAIL pre_reset_dl: got %b expected %b", dl_active, 1'b1); end
        reset = 1'b1;
        #1;
        n_tests++; if (dut_vec !== RESET_VEC) begin n_fail++; $display("FAIL async_reset: got %b expected %b", dut_vec, RESET_VEC); end
        #2;
        reset = 1'b0;
        model_reset();
        pct0 = 4'd0; pct1 = 4'd0;
        tick();
        n_tests++; if (dut_vec !== RESET_VEC) begin n_fail++; $display("FAIL post_reset_idle: got %b expected %b", dut_vec, RESET_VEC); end
    endtask

    function automatic logic [3:0] drive(input int lvl);
        if (lvl >= 10) return 4'(10 + $urandom_range(0, 5));
        return 4'(lvl);
    endfunction

    // Emulated buffers follow the model's requests, so the loop is independent of the DUT.
    task automatic test_random();
        int bufv[2];
        logic [11:0] e;
        do_reset();
        exp_q.delete();
        bufv[0] = 0; bufv[1] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc == 2000) begin
                do_reset();
                exp_q.delete();
                bufv[0] = 0; bufv[1] = 0;
            end
            start     = !m_started && ($urandom_range(0, 3) == 0);
            first_cam = 1'($urandom_range(0, 1));
            dl_req    = ($urandom_range(0, 15) == 0);
            pct0      = drive(bufv[0]);
            pct1      = drive(bufv[1]);
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (dut_vec !== e) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %b expected %b", cyc, dut_vec, e);
            end
            for (int i = 0; i < 2; i++) begin
                if (e[8+i] && bufv[i] < 10 && $urandom_range(0, 2) != 0) bufv[i]++;
                if (e[6+i] && bufv[i] > 0 && $urandom_range(0, 2) != 0)  bufv[i]--;
            end
        end
        dl_req = 1'b0;
        start  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_handoff();
        test_download();
        test_hold_flush();
        test_stall();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
